// File: rtl/simon_pkg.sv
// Shared SIMON key-schedule definitions: z sequences, the legal (N, m)
// configuration table and the controller state type.
package simon_pkg;

  // Bit 61 holds z[0] and bit 0 holds z[61], in the published left-to-right order.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [6:0] simon_rounds(input int n, input logic [2:0] m);
    logic [6:0] r;
    r = 7'd0;
    case (n)
      16: r = (m == 3'd4) ? 7'd32 : 7'd0;
      24: r = (m == 3'd3 || m == 3'd4) ? 7'd36 : 7'd0;
      32: r = (m == 3'd3) ? 7'd42 : (m == 3'd4) ? 7'd44 : 7'd0;
      48: r = (m == 3'd2) ? 7'd52 : (m == 3'd3) ? 7'd54 : 7'd0;
      64: r = (m == 3'd2) ? 7'd68 : (m == 3'd3) ? 7'd69 : (m == 3'd4) ? 7'd72 : 7'd0;
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] simon_zsel(input int n, input logic [2:0] m);
    logic [2:0] j;
    j = 3'd0;
    case (n)
      24: j = (m == 3'd3) ? 3'd0 : 3'd1;
      32: j = (m == 3'd3) ? 3'd2 : 3'd3;
      48: j = (m == 3'd2) ? 3'd2 : 3'd3;
      64: j = (m == 3'd2) ? 3'd2 : (m == 3'd3) ? 3'd3 : 3'd4;
      default: j = 3'd0;
    endcase
    return j;
  endfunction

  function automatic logic simon_cfg_ok(input int n, input logic [2:0] m);
    return simon_rounds(n, m) != 7'd0;
  endfunction

  function automatic logic [61:0] simon_z(input logic [2:0] j);
    logic [61:0] z;
    case (j)
      3'd1:    z = Z1;
      3'd2:    z = Z2;
      3'd3:    z = Z3;
      3'd4:    z = Z4;
      default: z = Z0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/simon_key_word.sv
// Combinational SIMON next-key-word function, shared with the decrypt-side
// schedule: k[i+m] from k[i], k[i+1], k[i+m-1] and the z bit.
module simon_key_word #(
  parameter int N = 64
) (
  input  logic [N-1:0] k_i,
  input  logic [N-1:0] k_i1,
  input  logic [N-1:0] k_last,
  input  logic [2:0]   m,
  input  logic         zbit,
  output logic [N-1:0] k_next
);

  logic [N-1:0] rot3;
  logic [N-1:0] t;

  assign rot3   = {k_last[2:0], k_last[N-1:3]};
  assign t      = (m == 3'd4) ? (rot3 ^ k_i1) : rot3;
  assign k_next = ~k_i ^ {{(N-2){1'b0}}, 2'b11} ^ {{(N-1){1'b0}}, zbit} ^ t ^ {t[0], t[N-1:1]};

endmodule

// File: rtl/simon_key_expand.sv
// SIMON key-schedule streamer: loads an m-word master key and emits
// k[0..T-1] over valid/ready, one word per handshake, via a 4-word window.
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           res_n,
  input  logic           start,
  input  logic [2:0]     key_words,
  input  logic [4*N-1:0] key,
  input  logic           abort,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_key,
  output logic [6:0]     out_rnd,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
);

  if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_bad_width
    $error("simon_key_expand: unsupported word width N=%0d", N);
  end

  state_e       state_q, state_d;
  logic [N-1:0] window_q [4];
  logic [N-1:0] window_d [4];
  logic [6:0]   rnd_q, rnd_d, rounds_q, rounds_d;
  logic [2:0]   words_q, words_d, zSel_q, zSel_d;
  logic [5:0]   zIdx_q, zIdx_d;
  logic         done_q, done_d, cfgErr_q, cfgErr_d;
  logic [N-1:0] kLast, kNext;
  logic [61:0]  zSeq;
  logic         running, lastRnd;

  assign running = (state_q == RUN);
  assign lastRnd = (rnd_q == rounds_q - 7'd1);
  assign zSeq    = simon_z(zSel_q);

  always_comb begin
    case (words_q)
      3'd2:    kLast = window_q[1];
      3'd3:    kLast = window_q[2];
      default: kLast = window_q[3];
    endcase
  end

  simon_key_word #(.N(N)) u_word (
    .k_i    (window_q[0]),
    .k_i1   (window_q[1]),
    .k_last (kLast),
    .m      (words_q),
    .zbit   (zSeq[6'd61 - zIdx_q]),
    .k_next (kNext)
  );

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    rnd_d    = rnd_q;
    rounds_d = rounds_q;
    words_d  = words_q;
    zSel_d   = zSel_q;
    zIdx_d   = zIdx_q;
    done_d   = 1'b0;
    cfgErr_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (simon_cfg_ok(N, key_words)) begin
              state_d = RUN;
              for (int w = 0; w < 4; w++) window_d[w] = key[w*N +: N];
              rnd_d    = 7'd0;
              zIdx_d   = 6'd0;
              words_d  = key_words;
              rounds_d = simon_rounds(N, key_words);
              zSel_d   = simon_zsel(N, key_words);
            end else begin
              cfgErr_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            // New word lands in the slot that becomes k[i+m-1] after the shift.
            for (int w = 0; w < 3; w++) window_d[w] = window_q[w+1];
            case (words_q)
              3'd2:    window_d[1] = kNext;
              3'd3:    window_d[2] = kNext;
              default: window_d[3] = kNext;
            endcase
            rnd_d  = rnd_q + 7'd1;
            zIdx_d = (zIdx_q == 6'd61) ? 6'd0 : zIdx_q + 6'd1;
            if (lastRnd) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q  <= IDLE;
      for (int w = 0; w < 4; w++) window_q[w] <= '0;
      rnd_q    <= '0;
      rounds_q <= '0;
      words_q  <= '0;
      zSel_q   <= '0;
      zIdx_q   <= '0;
      done_q   <= 1'b0;
      cfgErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      rnd_q    <= rnd_d;
      rounds_q <= rounds_d;
      words_q  <= words_d;
      zSel_q   <= zSel_d;
      zIdx_q   <= zIdx_d;
      done_q   <= done_d;
      cfgErr_q <= cfgErr_d;
    end
  end

  assign out_valid = running;
  assign out_key   = running ? window_q[0] : '0;
  assign out_rnd   = running ? rnd_q : '0;
  assign out_last  = running & lastRnd;
  assign busy      = running;
  assign done      = done_q;
  assign cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_simon_key_expand.sv
// Self-checking bench for simon_key_expand: N=16 and N=64 instances checked
// against a word-level key-schedule model and published SIMON test vectors.
module tb_simon_key_expand;

  logic         clk = 1'b0;
  logic         res_n, abort, outReady, start16, start64, sel;
  logic [2:0]   keyWords;
  logic [63:0]  key16;
  logic [255:0] key64;

  logic         v16, last16, busy16, done16, cfg16;
  logic [15:0]  oKey16;
  logic [6:0]   rnd16;
  logic         v64, last64, busy64, done64, cfg64;
  logic [63:0]  oKey64;
  logic [6:0]   rnd64;

  logic         oValid, oLast, oBusy, oDone, oCfg;
  logic [63:0]  oKey;
  logic [6:0]   oRnd;

  int checks = 0;
  int errors = 0;

  logic [63:0] expKeys [72];
  logic [63:0] obsKeys [72];

  string zTab [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"};

  simon_key_expand #(.N(16)) dut16 (
    .clk(clk), .res_n(res_n), .start(start16), .key_words(keyWords), .key(key16),
    .abort(abort), .out_ready(outReady), .out_valid(v16), .out_key(oKey16),
    .out_rnd(rnd16), .out_last(last16), .busy(busy16), .done(done16), .cfg_err(cfg16));

  simon_key_expand #(.N(64)) dut64 (
    .clk(clk), .res_n(res_n), .start(start64), .key_words(keyWords), .key(key64),
    .abort(abort), .out_ready(outReady), .out_valid(v64), .out_key(oKey64),
    .out_rnd(rnd64), .out_last(last64), .busy(busy64), .done(done64), .cfg_err(cfg64));

  assign oValid = sel ? v64 : v16;
  assign oKey   = sel ? oKey64 : {48'd0, oKey16};
  assign oRnd   = sel ? rnd64 : rnd16;
  assign oLast  = sel ? last64 : last16;
  assign oBusy  = sel ? busy64 : busy16;
  assign oDone  = sel ? done64 : done16;
  assign oCfg   = sel ? cfg64 : cfg16;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the run finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int refRounds(input int n, input int m);
    if (n == 16) return 32;
    if (m == 2) return 68;
    if (m == 3) return 69;
    return 72;
  endfunction

  function automatic int refZ(input int n, input int m);
    if (n == 16) return 0;
    return m;
  endfunction

  function automatic logic [63:0] maskOf(input int n);
    return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    return ((x >> r) | (x << (n - r))) & maskOf(n);
  endfunction

  function automatic logic zBit(input int j, input int i);
    string s;
    s = zTab[j];
    return s.getc(i % 62) == "1";
  endfunction

  // Key schedule straight from the published recurrence on a flat array.
  task automatic refKeys(input int n, input int m, input logic [255:0] k, input int t);
    logic [63:0] tmp;
    for (int i = 0; i < m; i++) expKeys[i] = 64'(k >> (i * n)) & maskOf(n);
    for (int i = m; i < t; i++) begin
      tmp = ror(expKeys[i-1], 3, n);
      if (m == 4) tmp = tmp ^ expKeys[i-3];
      tmp = tmp ^ ror(tmp, 1, n);
      expKeys[i] = (~expKeys[i-m] ^ 64'd3 ^ 64'(zBit(refZ(n, m), i - m)) ^ tmp) & maskOf(n);
    end
  endtask

  function automatic logic [127:0] encrypt(input int n, input int t, input logic [63:0] x0, input logic [63:0] y0);
    logic [63:0] x, y, tmp, f;
    x = x0;
    y = y0;
    for (int i = 0; i < t; i++) begin
      f = (ror(x, n - 1, n) & ror(x, n - 8, n)) ^ ror(x, n - 2, n);
      tmp = x;
      x = (y ^ f ^ obsKeys[i]) & maskOf(n);
      y = tmp;
    end
    return {x, y};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(oValid), 64'd0);
    checkOutput({tag, "_key"},   oKey, 64'd0);
    checkOutput({tag, "_rnd"},   64'(oRnd), 64'd0);
    checkOutput({tag, "_last"},  64'(oLast), 64'd0);
    checkOutput({tag, "_busy"},  64'(oBusy), 64'd0);
    checkOutput({tag, "_done"},  64'(oDone), 64'd0);
    checkOutput({tag, "_cfg"},   64'(oCfg), 64'd0);
  endtask

  // Runs one job; stopAt >= 0 interrupts at that round with abort or reset.
  task automatic applyStimulus(input bit big, input int m, input logic [255:0] k,
                               input bit randReady, input int stopAt, input bit stopByReset);
    int n, t, idx, cyc;
    n = big ? 64 : 16;
    t = refRounds(n, m);
    refKeys(n, m, k, t);
    sel = big;
    keyWords = 3'(m);
    if (big) key64 = k; else key16 = k[63:0];
    if (big) start64 = 1'b1; else start16 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    start16 = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < t && cyc < 4 * t + 20) begin
      checkOutput("valid", 64'(oValid), 64'd1);
      checkOutput("busy",  64'(oBusy), 64'd1);
      checkOutput("key",   oKey, expKeys[idx]);
      checkOutput("rnd",   64'(oRnd), 64'(idx));
      checkOutput("last",  64'(oLast), 64'(idx == t - 1));
      checkOutput("done_early", 64'(oDone), 64'd0);
      if (idx == stopAt) begin
        if (stopByReset) res_n = 1'b0; else abort = 1'b1;
        outReady = 1'b1;
        @(posedge clk); #1;
        res_n = 1'b1;
        abort = 1'b0;
        outReady = 1'b0;
        if (stopByReset) begin
          checkIdleZero("reset_mid");
        end else begin
          checkOutput("abort_valid", 64'(oValid), 64'd0);
          checkOutput("abort_busy",  64'(oBusy), 64'd0);
        end
        @(posedge clk); #1;
        checkOutput("interrupt_no_done", 64'(oDone), 64'd0);
        checkOutput("interrupt_idle", 64'(oValid), 64'd0);
        return;
      end
      outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (outReady) begin
        obsKeys[idx] = oKey;
        idx++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    outReady = 1'b0;
    checkOutput("stream_len", 64'(idx), 64'(t));
    checkOutput("done_pulse", 64'(oDone), 64'd1);
    checkOutput("end_valid", 64'(oValid), 64'd0);
    checkOutput("end_busy", 64'(oBusy), 64'd0);
    @(posedge clk); #1;
    checkOutput("done_once", 64'(oDone), 64'd0);
  endtask

  initial begin
    logic [255:0] rk;
    logic [127:0] ct;
    res_n = 1'b0; abort = 1'b0; outReady = 1'b0; start16 = 1'b0; start64 = 1'b0;
    keyWords = 3'd0; key16 = '0; key64 = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleZero("reset16");
    sel = 1'b1;
    #1;
    checkIdleZero("reset64");
    res_n = 1'b1;

    $display("[TB] SIMON32/64 vector");
    applyStimulus(1'b0, 4, 256'h1918111009080100, 1'b0, -1, 1'b0);
    checkOutput("k16_0", obsKeys[0], 64'h0100);
    checkOutput("k16_1", obsKeys[1], 64'h0908);
    checkOutput("k16_2", obsKeys[2], 64'h1110);
    checkOutput("k16_3", obsKeys[3], 64'h1918);
    ct = encrypt(16, 32, 64'h6565, 64'h6877);
    checkOutput("ct16_hi", ct[127:64], 64'hc69b);
    checkOutput("ct16_lo", ct[63:0],   64'he9bb);

    $display("[TB] illegal pairing N=16 m=2");
    sel = 1'b0;
    keyWords = 3'd2;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    checkOutput("cfg_err_pulse", 64'(oCfg), 64'd1);
    checkOutput("cfg_busy", 64'(oBusy), 64'd0);
    checkOutput("cfg_valid", 64'(oValid), 64'd0);
    @(posedge clk); #1;
    checkOutput("cfg_err_clear", 64'(oCfg), 64'd0);
    checkOutput("cfg_busy2", 64'(oBusy), 64'd0);
    checkOutput("cfg_valid2", 64'(oValid), 64'd0);

    $display("[TB] SIMON128/256 vector");
    applyStimulus(1'b1, 4, 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100,
                  1'b0, -1, 1'b0);
    checkOutput("k64_0", obsKeys[0], 64'h0706050403020100);
    ct = encrypt(64, 72, 64'h74206e69206d6f6f, 64'h6d69732061207369);
    checkOutput("ct64_hi", ct[127:64], 64'h8d2b5579afc8a3a0);
    checkOutput("ct64_lo", ct[63:0],   64'h3bf72a87efe7b868);

    $display("[TB] random keys with back-pressure");
    for (int m = 2; m <= 4; m++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(1'b1, m, rk, 1'b1, -1, 1'b0);
    end
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b0, 4, rk, 1'b1, -1, 1'b0);

    $display("[TB] abort and reset mid-job");
    rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 4, rk, 1'b0, 10, 1'b0);
    applyStimulus(1'b1, 3, rk, 1'b0, 20, 1'b1);
    applyStimulus(1'b1, 3, rk, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
